memory: RTL and testbench
=========================

Name: memory

Overview:
- MIPS memory-access stage. Sits between the EX/MEM and MEM/WB pipeline registers, and drives the write-back stage directly.
- Performs loads and stores over a req/ack data-memory bus, including byte-lane steering and sign/zero extension.
- Stalls the upstream pipeline while an access is outstanding.
- Owns the MEM/WB pipeline register.

Parameters:
- ADDR_SIZE, 5, register-file address width.
- WORD_SIZE, 32, datapath width. Must be 32 because byte-lane logic is fixed at 4 lanes.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- alu_data_ex_mem  in  WORD_SIZE  ALU result, or effective address for loads/stores.
- mem_data_ex_mem  in  WORD_SIZE  store data (rt).
- rd_en_ex_mem  in  1  register write enable.
- rd_addr_ex_mem  in  ADDR_SIZE  destination register.
- mem_rd_en_ex_mem  in  1  instruction is a load.
- mem_wr_en_ex_mem  in  1  instruction is a store.
- mem_size_ex_mem  in  2  access size: 0 byte, 1 half, 2 word, 3 treated as word.
- mem_signed_ex_mem  in  1  load sign-extends (1) or zero-extends (0).
- stall_mem  out  1  hold EX/MEM and all earlier stages this cycle.
- addr_err_mem_wb  out  1  misaligned access flag, aligned with the MEM/WB entry.
- dmem_req  out  1  bus request.
- dmem_we  out  1  write strobe.
- dmem_addr  out  WORD_SIZE  word-aligned address; bits [1:0] are always 0.
- dmem_be  out  4  byte enables, big-endian lanes (be[3] = bits 31:24 = byte offset 0).
- dmem_wdata  out  WORD_SIZE  store data, replicated across lanes.
- dmem_rdata  in  WORD_SIZE  load data, valid when dmem_ack=1.
- dmem_ack  in  1  access complete.
- alu_data_mem_wb  out  WORD_SIZE  registered ALU result.
- mem_data_mem_wb  out  WORD_SIZE  registered, extended load data; 0 for non-loads.
- rd_en_mem_wb  out  1  registered write enable.
- rd_addr_mem_wb  out  ADDR_SIZE  registered destination register.
- rd_data_sel_mem_wb  out  1  1 = write-back takes mem_data, 0 = takes alu_data.

Behaviour:
- Reset: state=IDLE. All registered outputs and dmem_* outputs are 0. stall_mem=0.
- Instruction classes:
  - mem op = mem_rd_en_ex_mem | mem_wr_en_ex_mem. If both are set, treat as load.
  - Aligned: byte always; half needs addr[0]=0; word needs addr[1:0]=0.
- FSM, two states:
  - IDLE, non-mem op: MEM/WB loads the EX/MEM fields at the next edge. Latency 1. rd_data_sel=0, mem_data=0.
  - IDLE, misaligned mem op: no bus access. MEM/WB loads with rd_en=0, addr_err=1, rd_data_sel=0. stall_mem=0.
  - IDLE, aligned mem op: stall_mem=1 combinationally. At the edge, latch address, we, be, wdata, size, signed, rd fields; go to ACCESS. MEM/WB loads a bubble (rd_en=0, addr_err=0, sel=0, data=0).
  - ACCESS: dmem_req=1, with dmem_addr/we/be/wdata driven from the latched registers and held stable until ack.
    - stall_mem = ~dmem_ack.
    - On dmem_ack: MEM/WB loads the latched instruction. For loads, sel=1 and extracted data. For stores, sel=0 and mem_data=0. Return to IDLE.
    - While waiting: MEM/WB loads a bubble each cycle.
- Minimum mem-op latency is 2 cycles (ack in the first ACCESS cycle). Back-to-back mem ops each take ≥2 cycles.
- dmem_req is a decode of the registered state. It deasserts the cycle after ack.
- dmem_ack is ignored outside ACCESS.
- Byte enables, by offset o = addr[1:0]:
  - byte: be = 4'b1000 >> o.
  - half: o=0 → 1100, o=2 → 0011.
  - word: 1111.
- Write data:
  - byte: {4{d[7:0]}}.
  - half: {2{d[15:0]}}.
  - word: d.
- Load extraction:
  - byte: bits [31-8o -: 8].
  - half: o=0 → [31:16], o=2 → [15:0].
  - word: all.
  - Then extend to 32 bits per mem_signed.
- Reset mid-ACCESS: the FSM goes to IDLE at that edge and the request is dropped. A late ack is ignored.
- rd_en passes through unchanged for stores. Clearing it for stores is the decoder's job.

Test Plan:
- IDLE, addu result 0xDEADBEEF, rd_addr=5, rd_en=1 → next cycle: alu_data_mem_wb=0xDEADBEEF, rd_en=1, rd_addr=5, sel=0, dmem_req never asserted, stall_mem=0.
- lw at 0x1000, ack after 3 ACCESS cycles with rdata=0x12345678:
  - dmem_addr=0x1000, be=1111.
  - stall_mem high for 4 cycles; MEM/WB holds a bubble during that time.
  - Then mem_data=0x12345678, sel=1.
- lb at 0x2003 with rdata=0x123456F0 → be=0001, mem_data=0xFFFFFFF0. Same access as lbu → 0x000000F0.
- sh at 0x3002 with data 0x0000ABCD → dmem_we=1, be=0011, wdata=0xABCDABCD. After ack, sel=0 and mem_data=0.
- lw at 0x1002 → no dmem_req. Next cycle addr_err_mem_wb=1 and rd_en_mem_wb=0. stall_mem never asserted.
- rst asserted during ACCESS before ack → next cycle dmem_req=0 and all outputs are 0. An ack one cycle later causes no MEM/WB update.

Source files
------------

// File: rtl/memory.sv
// MIPS memory-access stage: req/ack data-memory bus with byte-lane steering
// and load extension, a stall while an access is outstanding, and the MEM/WB register.
module memory #(
   parameter int ADDR_SIZE = 5,
   parameter int WORD_SIZE = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [WORD_SIZE-1:0] alu_data_ex_mem,
   input  logic [WORD_SIZE-1:0] mem_data_ex_mem,
   input  logic                 rd_en_ex_mem,
   input  logic [ADDR_SIZE-1:0] rd_addr_ex_mem,
   input  logic                 mem_rd_en_ex_mem,
   input  logic                 mem_wr_en_ex_mem,
   input  logic [1:0]           mem_size_ex_mem,
   input  logic                 mem_signed_ex_mem,
   output logic                 stall_mem,
   output logic                 addr_err_mem_wb,
   output logic                 dmem_req,
   output logic                 dmem_we,
   output logic [WORD_SIZE-1:0] dmem_addr,
   output logic [3:0]           dmem_be,
   output logic [WORD_SIZE-1:0] dmem_wdata,
   input  logic [WORD_SIZE-1:0] dmem_rdata,
   input  logic                 dmem_ack,
   output logic [WORD_SIZE-1:0] alu_data_mem_wb,
   output logic [WORD_SIZE-1:0] mem_data_mem_wb,
   output logic                 rd_en_mem_wb,
   output logic [ADDR_SIZE-1:0] rd_addr_mem_wb,
   output logic                 rd_data_sel_mem_wb,
   output logic                 dbg_state
);

   typedef enum logic {S_IDLE = 1'b0, S_ACCESS = 1'b1} state_t;

   state_t r_state;
   state_t w_state_next;

   logic [WORD_SIZE-1:0] r_alu;
   logic [WORD_SIZE-1:0] r_wdata;
   logic [3:0]           r_be;
   logic                 r_we;
   logic                 r_is_load;
   logic [1:0]           r_size;
   logic                 r_signed;
   logic                 r_rd_en;
   logic [ADDR_SIZE-1:0] r_rd_addr;

   logic                 w_mem_op;
   logic                 w_aligned;
   logic [3:0]           w_be;
   logic [WORD_SIZE-1:0] w_wdata;
   logic                 w_start;
   logic                 w_misaligned;
   logic                 w_in_access;
   logic [7:0]           w_byte;
   logic [15:0]          w_half;
   logic [WORD_SIZE-1:0] w_load;

   assign w_mem_op     = mem_rd_en_ex_mem | mem_wr_en_ex_mem;
   assign w_in_access  = (r_state == S_ACCESS);
   assign w_start      = (r_state == S_IDLE) & w_mem_op & w_aligned;
   assign w_misaligned = (r_state == S_IDLE) & w_mem_op & ~w_aligned;

   // Lane steering for the incoming instruction; size 3 falls into the word case.
   always_comb begin
      w_aligned = 1'b1;
      w_be      = 4'b1111;
      w_wdata   = mem_data_ex_mem;
      case (mem_size_ex_mem)
         2'b00: begin
            w_be    = 4'b1000 >> alu_data_ex_mem[1:0];
            w_wdata = {4{mem_data_ex_mem[7:0]}};
         end
         2'b01: begin
            w_aligned = ~alu_data_ex_mem[0];
            w_be      = alu_data_ex_mem[1] ? 4'b0011 : 4'b1100;
            w_wdata   = {2{mem_data_ex_mem[15:0]}};
         end
         default: begin
            w_aligned = (alu_data_ex_mem[1:0] == 2'b00);
         end
      endcase
   end

   // Load extraction from the latched offset; lane 0 is the most significant byte.
   always_comb begin
      w_byte = dmem_rdata[31:24];
      w_half = dmem_rdata[31:16];
      w_load = dmem_rdata;
      case (r_alu[1:0])
         2'b00:   w_byte = dmem_rdata[31:24];
         2'b01:   w_byte = dmem_rdata[23:16];
         2'b10:   w_byte = dmem_rdata[15:8];
         default: w_byte = dmem_rdata[7:0];
      endcase
      if (r_alu[1]) begin
         w_half = dmem_rdata[15:0];
      end
      case (r_size)
         2'b00:   w_load = {{24{r_signed & w_byte[7]}}, w_byte};
         2'b01:   w_load = {{16{r_signed & w_half[15]}}, w_half};
         default: w_load = dmem_rdata;
      endcase
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:   if (w_start)  w_state_next = S_ACCESS;
         S_ACCESS: if (dmem_ack) w_state_next = S_IDLE;
         default:  w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   assign stall_mem  = w_start | (w_in_access & ~dmem_ack);
   assign dbg_state  = r_state;
   assign dmem_req   = w_in_access;
   assign dmem_we    = w_in_access & r_we;
   assign dmem_addr  = w_in_access ? {r_alu[WORD_SIZE-1:2], 2'b00} : '0;
   assign dmem_be    = w_in_access ? r_be : 4'b0000;
   assign dmem_wdata = w_in_access ? r_wdata : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_alu     <= '0;
         r_wdata   <= '0;
         r_be      <= '0;
         r_we      <= 1'b0;
         r_is_load <= 1'b0;
         r_size    <= '0;
         r_signed  <= 1'b0;
         r_rd_en   <= 1'b0;
         r_rd_addr <= '0;
      end else if (w_start) begin
         r_alu     <= alu_data_ex_mem;
         r_wdata   <= w_wdata;
         r_be      <= w_be;
         r_we      <= ~mem_rd_en_ex_mem;
         r_is_load <= mem_rd_en_ex_mem;
         r_size    <= mem_size_ex_mem;
         r_signed  <= mem_signed_ex_mem;
         r_rd_en   <= rd_en_ex_mem;
         r_rd_addr <= rd_addr_ex_mem;
      end
   end

   // MEM/WB: pass-through, error entry, completed access, or a bubble.
   always_ff @(posedge clk) begin
      if (rst) begin
         alu_data_mem_wb    <= '0;
         mem_data_mem_wb    <= '0;
         rd_en_mem_wb       <= 1'b0;
         rd_addr_mem_wb     <= '0;
         rd_data_sel_mem_wb <= 1'b0;
         addr_err_mem_wb    <= 1'b0;
      end else if (w_in_access ? dmem_ack : ~w_start) begin
         if (w_in_access) begin
            alu_data_mem_wb    <= r_alu;
            mem_data_mem_wb    <= r_is_load ? w_load : '0;
            rd_en_mem_wb       <= r_rd_en;
            rd_addr_mem_wb     <= r_rd_addr;
            rd_data_sel_mem_wb <= r_is_load;
            addr_err_mem_wb    <= 1'b0;
         end else begin
            alu_data_mem_wb    <= alu_data_ex_mem;
            mem_data_mem_wb    <= '0;
            rd_en_mem_wb       <= rd_en_ex_mem & ~w_misaligned;
            rd_addr_mem_wb     <= rd_addr_ex_mem;
            rd_data_sel_mem_wb <= 1'b0;
            addr_err_mem_wb    <= w_misaligned;
         end
      end else begin
         alu_data_mem_wb    <= '0;
         mem_data_mem_wb    <= '0;
         rd_en_mem_wb       <= 1'b0;
         rd_addr_mem_wb     <= '0;
         rd_data_sel_mem_wb <= 1'b0;
         addr_err_mem_wb    <= 1'b0;
      end
   end

endmodule

// File: tb/tb_memory.sv
// Directed and randomized bench for the memory stage: an expected queue of
// MEM/WB entries plus direct checks of the bus and stall behaviour.
module tb_memory;

   localparam int AW = 5;
   localparam int W  = 32;
   localparam int EW = 72;

   logic          clk = 1'b0;
   logic          rst;
   logic [W-1:0]  alu_data_ex_mem, mem_data_ex_mem;
   logic          rd_en_ex_mem;
   logic [AW-1:0] rd_addr_ex_mem;
   logic          mem_rd_en_ex_mem, mem_wr_en_ex_mem;
   logic [1:0]    mem_size_ex_mem;
   logic          mem_signed_ex_mem;
   logic          stall_mem, addr_err_mem_wb;
   logic          dmem_req, dmem_we;
   logic [W-1:0]  dmem_addr, dmem_wdata, dmem_rdata;
   logic [3:0]    dmem_be;
   logic          dmem_ack;
   logic [W-1:0]  alu_data_mem_wb, mem_data_mem_wb;
   logic          rd_en_mem_wb;
   logic [AW-1:0] rd_addr_mem_wb;
   logic          rd_data_sel_mem_wb;
   logic          dbg_state;

   int n_checks = 0;
   int n_fail   = 0;

   logic [EW-1:0] exp_q[$];
   logic [EW-1:0] mask_q[$];

   logic [1:0]  t_off, t_size;
   logic        t_sg;
   logic [3:0]  t_be;
   logic [31:0] t_alu, t_rdata;

   memory #(.ADDR_SIZE(AW), .WORD_SIZE(W)) dut (
      .clk(clk), .rst(rst),
      .alu_data_ex_mem(alu_data_ex_mem), .mem_data_ex_mem(mem_data_ex_mem),
      .rd_en_ex_mem(rd_en_ex_mem), .rd_addr_ex_mem(rd_addr_ex_mem),
      .mem_rd_en_ex_mem(mem_rd_en_ex_mem), .mem_wr_en_ex_mem(mem_wr_en_ex_mem),
      .mem_size_ex_mem(mem_size_ex_mem), .mem_signed_ex_mem(mem_signed_ex_mem),
      .stall_mem(stall_mem), .addr_err_mem_wb(addr_err_mem_wb),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
      .dmem_ack(dmem_ack),
      .alu_data_mem_wb(alu_data_mem_wb), .mem_data_mem_wb(mem_data_mem_wb),
      .rd_en_mem_wb(rd_en_mem_wb), .rd_addr_mem_wb(rd_addr_mem_wb),
      .rd_data_sel_mem_wb(rd_data_sel_mem_wb), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [EW-1:0] pack(input logic err, input logic sel, input logic rd_en,
                                          input logic [4:0] rd, input logic [31:0] mem,
                                          input logic [31:0] alu);
      return {err, sel, rd_en, rd, mem, alu};
   endfunction

   function automatic logic [EW-1:0] wb_obs();
      return pack(addr_err_mem_wb, rd_data_sel_mem_wb, rd_en_mem_wb, rd_addr_mem_wb,
                  mem_data_mem_wb, alu_data_mem_wb);
   endfunction

   // Reference extraction written as shift-and-mask rather than lane selection.
   function automatic logic [31:0] model_load(input logic [31:0] rdata, input logic [1:0] size,
                                              input logic [1:0] off, input logic sg);
      logic [31:0] v;
      if (size == 2'd0) begin
         v = (rdata >> (8 * (3 - int'(off)))) & 32'h0000_00FF;
         if (sg && v[7]) v = v | 32'hFFFF_FF00;
      end else if (size == 2'd1) begin
         v = (rdata >> (off[1] ? 0 : 16)) & 32'h0000_FFFF;
         if (sg && v[15]) v = v | 32'hFFFF_0000;
      end else begin
         v = rdata;
      end
      return v;
   endfunction

   task automatic set_nop();
      alu_data_ex_mem   = '0;
      mem_data_ex_mem   = '0;
      rd_en_ex_mem      = 1'b0;
      rd_addr_ex_mem    = '0;
      mem_rd_en_ex_mem  = 1'b0;
      mem_wr_en_ex_mem  = 1'b0;
      mem_size_ex_mem   = '0;
      mem_signed_ex_mem = 1'b0;
   endtask

   task automatic drive(input logic [31:0] alu, input logic [31:0] wd, input logic ld,
                        input logic st, input logic [1:0] size, input logic sg,
                        input logic rd_en, input logic [4:0] rd);
      alu_data_ex_mem   = alu;
      mem_data_ex_mem   = wd;
      mem_rd_en_ex_mem  = ld;
      mem_wr_en_ex_mem  = st;
      mem_size_ex_mem   = size;
      mem_signed_ex_mem = sg;
      rd_en_ex_mem      = rd_en;
      rd_addr_ex_mem    = rd;
   endtask

   task automatic pop_check(input string tag);
      logic [EW-1:0] e, m;
      if (exp_q.size() == 0) begin
         n_checks++;
         n_fail++;
         $error("FAIL %s observed=output expected=queued-entry", tag);
      end else begin
         e = exp_q.pop_front();
         m = mask_q.pop_front();
         check(tag, wb_obs() & m, e & m);
      end
   endtask

   task automatic do_alu(input logic [31:0] alu, input logic rd_en, input logic [4:0] rd,
                         input string tag);
      exp_q.push_back(pack(1'b0, 1'b0, rd_en, rd, 32'h0, alu));
      mask_q.push_back('1);
      @(negedge clk);
      drive(alu, 32'h1111_2222, 1'b0, 1'b0, 2'd2, 1'b0, rd_en, rd);
      #1;
      check({tag, "_stall"}, EW'(stall_mem), EW'(0));
      @(negedge clk);
      check({tag, "_req"}, EW'(dmem_req), EW'(0));
      pop_check({tag, "_wb"});
   endtask

   task automatic do_misaligned(input logic [31:0] alu, input logic ld, input logic st,
                                input logic [1:0] size, input string tag);
      exp_q.push_back(pack(1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0));
      mask_q.push_back(pack(1'b1, 1'b1, 1'b1, 5'd0, 32'hFFFF_FFFF, 32'h0));
      @(negedge clk);
      drive(alu, 32'h5555_AAAA, ld, st, size, 1'b0, 1'b1, 5'd9);
      #1;
      check({tag, "_stall"}, EW'(stall_mem), EW'(0));
      @(negedge clk);
      check({tag, "_req"}, EW'(dmem_req), EW'(0));
      check({tag, "_stall2"}, EW'(stall_mem), EW'(0));
      pop_check({tag, "_wb"});
   endtask

   task automatic do_mem(input logic [31:0] alu, input logic [31:0] wd, input logic ld,
                         input logic st, input logic [1:0] size, input logic sg,
                         input logic rd_en, input logic [4:0] rd, input int waits,
                         input logic [31:0] rdata, input logic [3:0] exp_be,
                         input logic [31:0] exp_wdata, input string tag);
      int stall_cnt;
      logic [31:0] exp_mem;
      exp_mem = ld ? model_load(rdata, size, alu[1:0], sg) : 32'h0;
      exp_q.push_back(pack(1'b0, ld, rd_en, rd, exp_mem, alu));
      mask_q.push_back('1);
      @(negedge clk);
      drive(alu, wd, ld, st, size, sg, rd_en, rd);
      #1;
      check({tag, "_stall_idle"}, EW'(stall_mem), EW'(1));
      check({tag, "_req_idle"}, EW'(dmem_req), EW'(0));
      stall_cnt = int'(stall_mem);
      @(negedge clk);
      for (int i = 0; i <= waits; i++) begin
         check({tag, "_req"}, EW'(dmem_req), EW'(1));
         check({tag, "_we"}, EW'(dmem_we), EW'(st & ~ld));
         check({tag, "_addr"}, EW'(dmem_addr), EW'({alu[31:2], 2'b00}));
         check({tag, "_be"}, EW'(dmem_be), EW'(exp_be));
         if (st && !ld) check({tag, "_wdata"}, EW'(dmem_wdata), EW'(exp_wdata));
         check({tag, "_bubble"},
               EW'({rd_en_mem_wb, rd_data_sel_mem_wb, addr_err_mem_wb, mem_data_mem_wb}),
               EW'(0));
         if (i < waits) begin
            stall_cnt += int'(stall_mem);
            @(negedge clk);
         end
      end
      dmem_ack   = 1'b1;
      dmem_rdata = rdata;
      #1;
      check({tag, "_stall_ack"}, EW'(stall_mem), EW'(0));
      check({tag, "_stall_cycles"}, EW'(stall_cnt), EW'(waits + 1));
      @(negedge clk);
      dmem_ack   = 1'b0;
      dmem_rdata = '0;
      set_nop();
      check({tag, "_req_after"}, EW'(dmem_req), EW'(0));
      pop_check({tag, "_wb"});
   endtask

   initial begin
      rst        = 1'b1;
      dmem_ack   = 1'b0;
      dmem_rdata = '0;
      set_nop();
      repeat (2) @(negedge clk);
      check("reset_wb", wb_obs(), '0);
      check("reset_bus", EW'({dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata}), '0);
      check("reset_stall", EW'({stall_mem, dbg_state}), '0);
      rst = 1'b0;

      do_alu(32'hDEAD_BEEF, 1'b1, 5'd5, "addu");
      do_mem(32'h0000_1000, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 5'd8, 3,
             32'h1234_5678, 4'b1111, 32'h0, "lw");
      do_mem(32'h0000_2003, 32'h0, 1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 5'd9, 1,
             32'h1234_56F0, 4'b0001, 32'h0, "lb");
      do_mem(32'h0000_2003, 32'h0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 5'd10, 1,
             32'h1234_56F0, 4'b0001, 32'h0, "lbu");
      do_mem(32'h0000_3002, 32'h0000_ABCD, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 5'd0, 0,
             32'hFFFF_FFFF, 4'b0011, 32'hABCD_ABCD, "sh");
      do_mem(32'h0000_3001, 32'h1234_5677, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 5'd3, 2,
             32'h0, 4'b0100, 32'h7777_7777, "sb");
      do_mem(32'h0000_3004, 32'hA5A5_0001, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 5'd0, 0,
             32'h0, 4'b1111, 32'hA5A5_0001, "sw");
      do_mem(32'h0000_3002, 32'h0, 1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 5'd11, 0,
             32'h1234_8001, 4'b0011, 32'h0, "lh");
      do_mem(32'h0000_3000, 32'h0, 1'b1, 1'b0, 2'd1, 1'b0, 1'b1, 5'd12, 1,
             32'h8234_0001, 4'b1100, 32'h0, "lhu");
      do_mem(32'h0000_5000, 32'hFFFF_0000, 1'b1, 1'b1, 2'd3, 1'b0, 1'b1, 5'd13, 0,
             32'hCAFE_0042, 4'b1111, 32'h0, "ld_st_both");
      do_misaligned(32'h0000_1002, 1'b1, 1'b0, 2'd2, "lw_mis");
      do_misaligned(32'h0000_1001, 1'b0, 1'b1, 2'd1, "sh_mis");
      do_misaligned(32'h0000_1003, 1'b1, 1'b0, 2'd3, "sz3_mis");
      do_alu(32'h0000_0001, 1'b0, 5'd31, "nop_rd_off");

      for (int k = 0; k < 6; k++) begin
         t_size = 2'($urandom_range(0, 1));
         t_off  = 2'($urandom_range(0, 3));
         if (t_size == 2'd1) t_off[0] = 1'b0;
         t_sg    = 1'($urandom_range(0, 1));
         t_alu   = {16'h0, 14'($urandom_range(0, 16383)), t_off};
         t_rdata = $urandom;
         t_be    = (t_size == 2'd0) ? (4'b1000 >> t_off) : (t_off[1] ? 4'b0011 : 4'b1100);
         do_mem(t_alu, 32'h0, 1'b1, 1'b0, t_size, t_sg, 1'b1, 5'($urandom_range(1, 31)),
                $urandom_range(0, 2), t_rdata, t_be, 32'h0, "rnd_load");
         do_alu($urandom, 1'b1, 5'($urandom_range(1, 31)), "rnd_alu");
      end

      // Reset in the middle of an access, then a stray ack.
      @(negedge clk);
      drive(32'h0000_4000, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 5'd7);
      @(negedge clk);
      check("rst_mid_req_before", EW'(dmem_req), EW'(1));
      rst = 1'b1;
      set_nop();
      @(negedge clk);
      check("rst_mid_wb", wb_obs(), '0);
      check("rst_mid_bus", EW'({dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata}), '0);
      check("rst_mid_stall", EW'({stall_mem, dbg_state}), '0);
      rst        = 1'b0;
      dmem_ack   = 1'b1;
      dmem_rdata = 32'hCAFE_F00D;
      @(negedge clk);
      dmem_ack = 1'b0;
      check("late_ack_wb", wb_obs(), '0);
      check("late_ack_req", EW'(dmem_req), EW'(0));
      check("queue_drained", EW'(exp_q.size()), EW'(0));

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
